// File: rtl/path_pkg.sv
// Shared path-record layout and the ordering used by the comparator and the sorted queue.
// The ordering key is f = g + h (mod 2^KEY_W); g breaks ties; flag and payload do not affect order.
package path_pkg;

  localparam int PATH_W  = 65;
  localparam int KEY_W   = 16;
  localparam int H_LSB   = 1;
  localparam int G_LSB   = 17;
  localparam int PAY_LSB = 33;

  localparam logic [1:0] ORD_LT = 2'd0;
  localparam logic [1:0] ORD_EQ = 2'd1;
  localparam logic [1:0] ORD_GT = 2'd2;

  // Per-cell next-value source for the shift-register queue.
  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LEFT,
    SEL_RIGHT,
    SEL_NEW
  } cell_sel_e;

  function automatic logic [1:0] path_cmp(input logic [PATH_W-1:0] a,
                                          input logic [PATH_W-1:0] b);
    logic [KEY_W-1:0] ga, gb, fa, fb;
    ga = a[G_LSB +: KEY_W];
    gb = b[G_LSB +: KEY_W];
    fa = ga + a[H_LSB +: KEY_W];
    fb = gb + b[H_LSB +: KEY_W];
    if (fa < fb)      return ORD_LT;
    else if (fa > fb) return ORD_GT;
    else if (ga < gb) return ORD_LT;
    else if (ga > gb) return ORD_GT;
    else              return ORD_EQ;
  endfunction

endpackage

// File: rtl/path_pq_cell.sv
// One slot of the sorted queue: holds a record and picks its next value from itself,
// a neighbour, or the incoming record, based on its own and neighbouring "new is below me" bits.
module path_pq_cell
  import path_pkg::*;
#(
  parameter bit FIRST = 1'b0
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              i_ins_fire,
  input  logic              i_pop_fire,
  input  logic [PATH_W-1:0] i_new,
  input  logic              i_left_valid,
  input  logic [PATH_W-1:0] i_left_data,
  input  logic              i_left_lt,
  input  logic              i_right_valid,
  input  logic [PATH_W-1:0] i_right_data,
  input  logic              i_right_lt,
  output logic              o_valid,
  output logic [PATH_W-1:0] o_data,
  output logic              o_lt
);

  logic              r_valid;
  logic [PATH_W-1:0] r_data;
  logic              w_self_lt;
  cell_sel_e         w_sel;

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_lt    = !r_valid | (path_cmp(i_new, r_data) == ORD_LT);

  // On pop+insert the head is leaving, so cell 0 must not let its own record outrank the new one.
  assign w_self_lt = FIRST ? 1'b0 : o_lt;

  always_comb begin
    w_sel = SEL_HOLD;
    unique case ({i_ins_fire, i_pop_fire})
      2'b10: if (o_lt) w_sel = i_left_lt ? SEL_LEFT : SEL_NEW;
      2'b01: w_sel = SEL_RIGHT;
      2'b11: begin
        if (!i_right_lt)     w_sel = SEL_RIGHT;
        else if (!w_self_lt) w_sel = SEL_NEW;
        else                 w_sel = SEL_HOLD;
      end
      default: w_sel = SEL_HOLD;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      unique case (w_sel)
        SEL_LEFT: begin
          r_valid <= i_left_valid;
          r_data  <= i_left_data;
        end
        SEL_RIGHT: begin
          r_valid <= i_right_valid;
          r_data  <= i_right_data;
        end
        SEL_NEW: begin
          r_valid <= 1'b1;
          r_data  <= i_new;
        end
        default: begin
          r_valid <= r_valid;
          r_data  <= r_data;
        end
      endcase
    end
  end

endmodule

// File: rtl/path_pq_shift.sv
// Sorted shift-register priority queue of path records; cell 0 always holds the minimum.
// Insert and pop each complete in one cycle and may happen together, even when full.
module path_pq_shift
  import path_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PATH_W = 65,
  parameter int KEY_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              ins_valid,
  input  logic [PATH_W-1:0] ins_data,
  output logic              ins_ready,
  output logic              head_valid,
  output logic [PATH_W-1:0] head_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  if (DEPTH < 2 || PATH_W != 65 || KEY_W != 16 || CNT_W != $clog2(DEPTH+1)) begin : g_bad_params
    $error("path_pq_shift: unsupported parameter combination");
  end

  // Index 0 and DEPTH+1 are permanently-empty edge cells; cell i lives at index i+1.
  logic [DEPTH+1:0]  w_valid;
  logic [DEPTH+1:0]  w_lt;
  logic [PATH_W-1:0] w_data [DEPTH+2];
  logic              w_ins_fire;
  logic              w_pop_fire;
  logic [CNT_W-1:0]  r_count;

  assign w_valid[0]       = 1'b0;
  assign w_lt[0]          = 1'b0;
  assign w_data[0]        = '0;
  assign w_valid[DEPTH+1] = 1'b0;
  assign w_lt[DEPTH+1]    = 1'b1;
  assign w_data[DEPTH+1]  = '0;

  assign full       = (r_count == CNT_W'(DEPTH));
  assign ins_ready  = !full | pop;
  assign head_valid = w_valid[1];
  assign head_data  = w_data[1];
  assign count      = r_count;
  assign w_ins_fire = ins_valid & ins_ready;
  assign w_pop_fire = pop & head_valid;

  for (genvar i = 1; i <= DEPTH; i++) begin : g_cell
    path_pq_cell #(.FIRST(i == 1)) u_cell (
      .system1000    (system1000),
      .system1000_rst(system1000_rst),
      .i_ins_fire    (w_ins_fire),
      .i_pop_fire    (w_pop_fire),
      .i_new         (ins_data),
      .i_left_valid  (w_valid[i-1]),
      .i_left_data   (w_data[i-1]),
      .i_left_lt     (w_lt[i-1]),
      .i_right_valid (w_valid[i+1]),
      .i_right_data  (w_data[i+1]),
      .i_right_lt    (w_lt[i+1]),
      .o_valid       (w_valid[i]),
      .o_data        (w_data[i]),
      .o_lt          (w_lt[i])
    );
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_count <= '0;
    end else if (w_ins_fire && !w_pop_fire) begin
      r_count <= r_count + 1'b1;
    end else if (w_pop_fire && !w_ins_fire) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_path_pq_shift.sv
// Randomised and directed bench for path_pq_shift against a queue-based reference model.
module tb_path_pq_shift;

  localparam int DEPTH = 8;

  logic        system1000 = 1'b0;
  logic        system1000_rst;
  logic        ins_valid;
  logic [64:0] ins_data;
  logic        ins_ready;
  logic        head_valid;
  logic [64:0] head_data;
  logic        pop;
  logic [3:0]  count;
  logic        full;

  int n_pass  = 0;
  int n_total = 0;

  logic [64:0] q[$];

  path_pq_shift #(.DEPTH(DEPTH), .PATH_W(65), .KEY_W(16), .CNT_W(4)) dut (
    .system1000    (system1000),
    .system1000_rst(system1000_rst),
    .ins_valid     (ins_valid),
    .ins_data      (ins_data),
    .ins_ready     (ins_ready),
    .head_valid    (head_valid),
    .head_data     (head_data),
    .pop           (pop),
    .count         (count),
    .full          (full)
  );

  always #5 system1000 = ~system1000;

  function automatic logic [64:0] mk(input int g, input int h, input int pay);
    logic [31:0] p;
    logic [15:0] gg, hh;
    p  = pay;
    gg = g[15:0];
    hh = h[15:0];
    return {p, gg, hh, 1'b0};
  endfunction

  // Sort key: f (mod 2^16) then g, as a single unsigned 32-bit number.
  function automatic logic [31:0] key(input logic [64:0] r);
    logic [15:0] f;
    f = r[32:17] + r[16:1];
    return {f, r[32:17]};
  endfunction

  // Stable insert: after every existing record with key <= new key.
  function automatic void model_insert(input logic [64:0] r);
    int pos;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (key(r) < key(q[i])) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, r);
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: apply inputs, compare every output with the model, advance the model.
  task automatic cyc(input logic iv, input logic [64:0] d, input logic p, input logic r);
    logic        m_full, m_ready, m_ins, m_pop;
    logic [64:0] m_head;
    ins_valid      = iv;
    ins_data       = d;
    pop            = p;
    system1000_rst = r;
    #1;
    m_full  = (q.size() == DEPTH);
    m_ready = !m_full || p;
    m_head  = (q.size() > 0) ? q[0] : 65'd0;
    chk("ins_ready",  {64'd0, ins_ready},  {64'd0, m_ready});
    chk("head_valid", {64'd0, head_valid}, {64'd0, q.size() > 0});
    chk("count",      {61'd0, count},      65'(q.size()));
    chk("full",       {64'd0, full},       {64'd0, m_full});
    chk("head_data",  head_data,           m_head);
    if (r) begin
      q.delete();
    end else begin
      m_ins = iv && m_ready;
      m_pop = p && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_ins) model_insert(d);
    end
    @(posedge system1000);
    #1;
  endtask

  task automatic drain();
    while (q.size() > 0) cyc(1'b0, 65'd0, 1'b1, 1'b0);
  endtask

  task automatic lit_head(input string name, input int g, input int h);
    logic [15:0] gg, hh;
    gg = g[15:0];
    hh = h[15:0];
    chk(name, {33'd0, head_data[32:1]}, {33'd0, gg, hh});
  endtask

  initial begin
    int fs[8];
    system1000_rst = 1'b1;
    ins_valid      = 1'b0;
    ins_data       = '0;
    pop            = 1'b0;
    @(posedge system1000);
    #1;
    cyc(1'b0, 65'd0, 1'b0, 1'b1);
    cyc(1'b0, 65'd0, 1'b0, 1'b0);
    chk("rst_count_lit", {61'd0, count}, 65'd0);
    chk("rst_ready_lit", {64'd0, ins_ready}, 65'd1);
    cyc(1'b0, 65'd0, 1'b1, 1'b0);
    cyc(1'b0, 65'd0, 1'b0, 1'b0);
    chk("empty_pop_lit", {64'd0, head_valid}, 65'd0);

    cyc(1'b1, mk(5, 5, 0), 1'b0, 1'b0);
    cyc(1'b1, mk(3, 3, 0), 1'b0, 1'b0);
    cyc(1'b1, mk(4, 9, 0), 1'b0, 1'b0);
    cyc(1'b1, mk(2, 8, 0), 1'b0, 1'b0);
    lit_head("seq_head0", 3, 3);
    cyc(1'b0, 65'd0, 1'b1, 1'b0);
    lit_head("seq_head1", 2, 8);
    cyc(1'b0, 65'd0, 1'b1, 1'b0);
    lit_head("seq_head2", 5, 5);
    cyc(1'b0, 65'd0, 1'b1, 1'b0);
    lit_head("seq_head3", 4, 9);
    cyc(1'b0, 65'd0, 1'b1, 1'b0);
    cyc(1'b0, 65'd0, 1'b0, 1'b0);

    cyc(1'b1, mk(4, 4, 1), 1'b0, 1'b0);
    cyc(1'b1, mk(4, 4, 2), 1'b0, 1'b0);
    chk("stable_pay1", {33'd0, head_data[64:33]}, 65'd1);
    cyc(1'b0, 65'd0, 1'b1, 1'b0);
    chk("stable_pay2", {33'd0, head_data[64:33]}, 65'd2);
    drain();

    fs = '{13, 10, 17, 11, 15, 12, 16, 14};
    foreach (fs[i]) cyc(1'b1, mk(fs[i], 0, i), 1'b0, 1'b0);
    chk("fill_full_lit", {64'd0, full}, 65'd1);
    cyc(1'b1, mk(5, 0, 99), 1'b0, 1'b0);
    chk("full_blocked_ready", {64'd0, ins_ready}, 65'd0);
    chk("full_blocked_count", {61'd0, count}, 65'd8);
    lit_head("full_blocked_head", 10, 0);
    cyc(1'b1, mk(5, 0, 99), 1'b1, 1'b0);
    lit_head("full_swap_head", 5, 0);
    chk("full_swap_count", {61'd0, count}, 65'd8);
    drain();

    cyc(1'b1, mk(16'hFFFF, 2, 7), 1'b0, 1'b0);
    cyc(1'b1, mk(0, 3, 8), 1'b0, 1'b0);
    lit_head("wrap_head", 16'hFFFF, 2);
    drain();

    for (int i = 0; i < 5; i++) cyc(1'b1, mk(i + 1, 2, i), 1'b0, 1'b0);
    chk("pre_rst_count", {61'd0, count}, 65'd5);
    cyc(1'b1, mk(0, 0, 3), 1'b1, 1'b1);
    chk("mid_rst_count", {61'd0, count}, 65'd0);
    chk("mid_rst_hv", {64'd0, head_valid}, 65'd0);

    for (int n = 0; n < 3000; n++) begin
      logic        iv, p, r;
      logic [15:0] g, h;
      iv = ($urandom_range(0, 99) < 60);
      p  = ($urandom_range(0, 99) < 40);
      r  = ($urandom_range(0, 499) == 0);
      g  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      h  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      cyc(iv, {32'($urandom), g, h, 1'($urandom)}, p, r);
    end
    cyc(1'b0, 65'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
